sdes_ctrl: RTL and testbench
============================

SDES_CTRL -- requirements
Module: sdes_ctrl

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed by the S-DES algorithm.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 mode  input  1  0 = encrypt, 1 = decrypt.
REQ-007 data_in  input  8  plaintext (encrypt) or ciphertext (decrypt).
REQ-008 key  input  10  S-DES key.
REQ-009 S0, S1  input  32 each  S-box tables, sampled only at acceptance.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 data_out  output  8  result byte.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 Acceptance SHALL occur in the cycle where in_valid and in_ready are both high; data_in, key, mode, S0 and S1 SHALL be registered then.
REQ-015 FSM states SHALL be IDLE, KEYGEN, ROUND1, ROUND2, DONE; in_ready SHALL be high only in IDLE.
REQ-016 IDLE->KEYGEN on acceptance; KEYGEN->ROUND1; ROUND1->ROUND2; ROUND2->DONE; DONE->IDLE when out_ready is high; otherwise DONE holds.
REQ-017 KEYGEN SHALL compute K1 and K2 with P10, LS-1, P8, LS-2, P8.
REQ-018 ROUND1 SHALL apply IP, then fk with K1 for encrypt or K2 for decrypt, then SW.
REQ-019 ROUND2 SHALL apply fk with the other subkey, then IP-inverse, and register the result into data_out.
REQ-020 An S-box lookup SHALL use a 4-bit input b[3:0]: row = {b[3],b[0]}, col = {b[2],b[1]}, idx = 4*row+col; the 2-bit entry is table bits [31-2*idx : 30-2*idx].
REQ-021 out_valid SHALL be high only in DONE; data_out SHALL remain stable while out_valid is high and out_ready is low.
REQ-022 Latency: acceptance at cycle T SHALL give out_valid at T+4.
REQ-023 in_valid while busy SHALL be ignored; changes to inputs after acceptance SHALL NOT affect the result in flight.
REQ-024 The block SHALL NOT assert in_ready in the same cycle that DONE completes; the next acceptance is possible one cycle after the DONE->IDLE handshake.

Reset
REQ-025 With reset low at a clock edge, the FSM SHALL go to IDLE, including mid-operation; the in-flight result SHALL be discarded.
REQ-026 Reset values: in_ready=1 after reset release, out_valid=0, busy=0, data_out=8'h00, subkeys=0, key cache invalid.

Configuration
REQ-027 Macro SDES_CTRL_KEY_CACHE_EN: when defined, the block SHALL keep the last key and its K1/K2 with a valid flag. Acceptance with an equal key and a set flag SHALL go IDLE->ROUND1, skipping KEYGEN, so out_valid arrives at T+3. Any KEYGEN SHALL refresh the cache. Reset SHALL clear the flag.
REQ-028 When SDES_CTRL_KEY_CACHE_EN is undefined, every request SHALL pass through KEYGEN, and no cache registers SHALL exist.

Structure
REQ-029 Package sdes_pkg SHALL hold the FSM state enum, the permutation index constants (P10, P8, P4, IP, IP-inverse, E/P) and the subkey width constant.
REQ-030 The round function SHALL be one combinational sub-module, sdes_fk (inputs: 8-bit block, 8-bit subkey, S0, S1; output: 8-bit block). It is instantiated once and reused in ROUND1 and ROUND2.

Verification
REQ-031 Standard vector encrypt: key=10'h282, data_in=8'h72, S0=32'h4EE427DE, S1=32'h1B87C493, mode=0 -> data_out=8'h77 with out_valid at T+4.
REQ-032 Decrypt of the same vector: mode=1, data_in=8'h77 -> data_out=8'h72.
REQ-033 Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays high, data_out stays 8'h77, in_ready stays 0; out_ready=1 -> IDLE the next cycle.
REQ-034 Reset mid-operation: pull reset low during ROUND1 -> next cycle IDLE, out_valid=0, in_ready=1; no result is emitted.
REQ-035 Key cache (macro defined): two back-to-back encrypts with key 10'h282 -> the second has out_valid at T+3 with a correct result. Changing key to 10'h000 -> T+4 again.
REQ-036 Busy ignore: pulse in_valid with data_in=8'hFF during KEYGEN -> it is ignored and the original result 8'h77 is delivered.

Source files
------------

// File: rtl/sdes_pkg.sv
// sdes_pkg -- shared definitions for the S-DES controller.
//   state_t            : controller FSM states
//   SUBKEY_W           : width of each round subkey
//   *_TAB              : permutation tables, 1-based positions counted from the MSB
//   p10/p8/p4/ip/ip_inv/ep, rol1/rol2, sbox : bit-level helpers built on the tables
package sdes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEYGEN,
        ST_ROUND1,
        ST_ROUND2,
        ST_DONE
    } state_t;

    localparam int SUBKEY_W = 8;

    localparam int P10_TAB [10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
    localparam int P8_TAB  [8]  = '{6, 3, 7, 4, 8, 5, 10, 9};
    localparam int P4_TAB  [4]  = '{2, 4, 3, 1};
    localparam int IP_TAB  [8]  = '{2, 6, 3, 1, 4, 8, 5, 7};
    localparam int IPI_TAB [8]  = '{4, 1, 3, 5, 7, 2, 8, 6};
    localparam int EP_TAB  [8]  = '{4, 1, 2, 3, 2, 3, 4, 1};

    // Output position i (from the MSB) takes input position TAB[i] (from the MSB).
    function automatic logic [9:0] p10(input logic [9:0] x);
        logic [9:0] y;
        for (int i = 0; i < 10; i++) y[9-i] = x[10-P10_TAB[i]];
        return y;
    endfunction

    function automatic logic [SUBKEY_W-1:0] p8(input logic [9:0] x);
        logic [SUBKEY_W-1:0] y;
        for (int i = 0; i < 8; i++) y[7-i] = x[10-P8_TAB[i]];
        return y;
    endfunction

    function automatic logic [3:0] p4(input logic [3:0] x);
        logic [3:0] y;
        for (int i = 0; i < 4; i++) y[3-i] = x[4-P4_TAB[i]];
        return y;
    endfunction

    function automatic logic [7:0] ip(input logic [7:0] x);
        logic [7:0] y;
        for (int i = 0; i < 8; i++) y[7-i] = x[8-IP_TAB[i]];
        return y;
    endfunction

    function automatic logic [7:0] ip_inv(input logic [7:0] x);
        logic [7:0] y;
        for (int i = 0; i < 8; i++) y[7-i] = x[8-IPI_TAB[i]];
        return y;
    endfunction

    function automatic logic [7:0] ep(input logic [3:0] x);
        logic [7:0] y;
        for (int i = 0; i < 8; i++) y[7-i] = x[4-EP_TAB[i]];
        return y;
    endfunction

    function automatic logic [4:0] rol1(input logic [4:0] x);
        return {x[3:0], x[4]};
    endfunction

    function automatic logic [4:0] rol2(input logic [4:0] x);
        return {x[2:0], x[4:3]};
    endfunction

    // Row from the outer bits, column from the inner bits; entry 0 sits in the table MSBs.
    function automatic logic [1:0] sbox(input logic [3:0] b, input logic [31:0] t);
        logic [3:0] idx;
        idx = {b[3], b[0], b[2], b[1]};
        return t[5'd31 - {idx, 1'b0} -: 2];
    endfunction

endpackage

// File: rtl/sdes_ctrl_if.sv
// sdes_ctrl_if -- request/response bundle of the S-DES controller.
//   request : in_valid, in_ready, mode, data_in, key, S0, S1
//   response: out_valid, out_ready, data_out
//   master  : requester side (testbench / upstream logic)
//   slave   : the controller
interface sdes_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic        mode;
    logic [7:0]  data_in;
    logic [9:0]  key;
    logic [31:0] S0;
    logic [31:0] S1;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  data_out;

    modport master (
        output in_valid, mode, data_in, key, S0, S1, out_ready,
        input  in_ready, out_valid, data_out
    );

    modport slave (
        input  in_valid, mode, data_in, key, S0, S1, out_ready,
        output in_ready, out_valid, data_out
    );
endinterface

// File: rtl/sdes_fk.sv
// sdes_fk -- S-DES round function fk (purely combinational).
//   blk_in  : 8-bit block {L, R}
//   subkey  : 8-bit round subkey
//   s0, s1  : packed S-box tables
//   blk_out : {L ^ F(R, subkey), R}
module sdes_fk
    import sdes_pkg::*;
(
    input  logic [7:0]          blk_in,
    input  logic [SUBKEY_W-1:0] subkey,
    input  logic [31:0]         s0,
    input  logic [31:0]         s1,
    output logic [7:0]          blk_out
);

    logic [7:0] mix;
    logic [3:0] f;

    always_comb begin
        mix     = ep(blk_in[3:0]) ^ subkey;
        f       = p4({sbox(mix[7:4], s0), sbox(mix[3:0], s1)});
        blk_out = {blk_in[7:4] ^ f, blk_in[3:0]};
    end

endmodule

// File: rtl/sdes_ctrl.sv
// sdes_ctrl -- sequenced S-DES encrypt/decrypt engine, one byte per request.
//   clk    : clock, rising edge
//   reset  : synchronous, active-low
//   bus    : sdes_ctrl_if.slave (valid/ready request, valid/ready response)
//   busy   : high whenever the FSM is not in IDLE
// Build option: SDES_CTRL_KEY_CACHE_EN keeps the last key's subkeys so a request
// with the same key skips KEYGEN.
//
//   state  | meaning
//   IDLE   | waiting for a request, in_ready high
//   KEYGEN | derive K1/K2 from the registered key
//   ROUND1 | IP, fk with first subkey, swap halves
//   ROUND2 | fk with second subkey, IP-inverse into data_out
//   DONE   | result held until out_ready
module sdes_ctrl
    import sdes_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    sdes_ctrl_if.slave  bus,
    output logic        busy
);

    state_t state, state_nxt;

    logic                accept;
    logic                cache_hit;
    logic [7:0]          data_r;
    logic [9:0]          key_r;
    logic                mode_r;
    logic [31:0]         s0_r;
    logic [31:0]         s1_r;
    logic [SUBKEY_W-1:0] k1, k2;
    logic [SUBKEY_W-1:0] k1_n, k2_n;
    logic [7:0]          blk;
    logic [7:0]          dout;
    logic [7:0]          fk_in;
    logic [SUBKEY_W-1:0] fk_key;
    logic [7:0]          fk_out;
    logic [9:0]          key_p10;
    logic [4:0]          lh1, rh1;

    assign accept = bus.in_valid && bus.in_ready;

`ifdef SDES_CTRL_KEY_CACHE_EN
    // key_r still holds the last accepted key here; cache_vld says K1/K2 belong to it.
    logic cache_vld;
    assign cache_hit = cache_vld && (bus.key == key_r);
`else
    assign cache_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b1;
        case (state)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                busy         = 1'b0;
                if (bus.in_valid) state_nxt = cache_hit ? ST_ROUND1 : ST_KEYGEN;
            end
            ST_KEYGEN: state_nxt = ST_ROUND1;
            ST_ROUND1: state_nxt = ST_ROUND2;
            ST_ROUND2: state_nxt = ST_DONE;
            ST_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        key_p10 = p10(key_r);
        lh1     = rol1(key_p10[9:5]);
        rh1     = rol1(key_p10[4:0]);
        k1_n    = p8({lh1, rh1});
        k2_n    = p8({rol2(lh1), rol2(rh1)});
    end

    // The single fk instance: ROUND1 works on IP(data), ROUND2 on the swapped block.
    // Decrypt simply reverses the subkey order.
    always_comb begin
        if (state == ST_ROUND1) begin
            fk_in  = ip(data_r);
            fk_key = mode_r ? k2 : k1;
        end else begin
            fk_in  = blk;
            fk_key = mode_r ? k1 : k2;
        end
    end

    sdes_fk u_fk (
        .blk_in  (fk_in),
        .subkey  (fk_key),
        .s0      (s0_r),
        .s1      (s1_r),
        .blk_out (fk_out)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            data_r <= '0;
            key_r  <= '0;
            mode_r <= 1'b0;
            s0_r   <= '0;
            s1_r   <= '0;
            k1     <= '0;
            k2     <= '0;
            blk    <= '0;
            dout   <= '0;
        end else begin
            if (accept) begin
                data_r <= bus.data_in;
                key_r  <= bus.key;
                mode_r <= bus.mode;
                s0_r   <= bus.S0;
                s1_r   <= bus.S1;
            end
            if (state == ST_KEYGEN) begin
                k1 <= k1_n;
                k2 <= k2_n;
            end
            if (state == ST_ROUND1) blk  <= {fk_out[3:0], fk_out[7:4]};
            if (state == ST_ROUND2) dout <= ip_inv(fk_out);
        end
    end

`ifdef SDES_CTRL_KEY_CACHE_EN
    always_ff @(posedge clk) begin
        if (!reset)                   cache_vld <= 1'b0;
        else if (state == ST_KEYGEN)  cache_vld <= 1'b1;
        else if (accept && !cache_hit) cache_vld <= 1'b0;
    end
`endif

    assign bus.data_out = dout;

endmodule

// File: tb/tb_sdes_ctrl.sv
module tb_sdes_ctrl;

    logic clk;
    logic reset;
    logic busy;
    int   n_chk;
    int   n_err;

    sdes_ctrl_if bus ();

    sdes_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] S0_STD = 32'h4EE427DE;
    localparam logic [31:0] S1_STD = 32'h1B87C493;

    // Permutation tables, 1-based positions from the MSB: P10, P8, P4, IP, IP^-1, E/P.
    int tabs [6][10] = '{
        '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6},
        '{6, 3, 7, 4, 8, 5, 10, 9, 0, 0},
        '{2, 4, 3, 1, 0, 0, 0, 0, 0, 0},
        '{2, 6, 3, 1, 4, 8, 5, 7, 0, 0},
        '{4, 1, 3, 5, 7, 2, 8, 6, 0, 0},
        '{4, 1, 2, 3, 2, 3, 4, 1, 0, 0}
    };

    // Reference model state for the key cache.
    bit       cvalid;
    logic [9:0] clast;

    function automatic int perm(input int x, input int n_in, input int n_out, input int w);
        int y;
        y = 0;
        for (int j = 1; j <= n_out; j++)
            y = y | (((x >> (n_in - tabs[w][j-1])) & 1) << (n_out - j));
        return y;
    endfunction

    function automatic int rol5(input int x, input int n);
        return ((x << n) | (x >> (5 - n))) & 31;
    endfunction

    function automatic int sb(input logic [31:0] t, input int b);
        int row, col;
        row = ((b >> 3) & 1) * 2 + (b & 1);
        col = ((b >> 2) & 1) * 2 + ((b >> 1) & 1);
        return int'((t >> (30 - 2 * (4 * row + col))) & 32'd3);
    endfunction

    function automatic int fk_ref(input int x, input int sk, input logic [31:0] t0, input logic [31:0] t1);
        int e, s, f;
        e = perm(x & 15, 4, 8, 5) ^ sk;
        s = (sb(t0, e >> 4) << 2) | sb(t1, e & 15);
        f = perm(s, 4, 4, 2);
        return ((((x >> 4) ^ f) & 15) << 4) | (x & 15);
    endfunction

    function automatic logic [7:0] sdes_ref(input logic m, input logic [7:0] d, input logic [9:0] k,
                                            input logic [31:0] t0, input logic [31:0] t1);
        int p, l, r, sk1, sk2, a;
        p   = perm(int'(k), 10, 10, 0);
        l   = rol5(p >> 5, 1);
        r   = rol5(p & 31, 1);
        sk1 = perm((l << 5) | r, 10, 8, 1);
        l   = rol5(l, 2);
        r   = rol5(r, 2);
        sk2 = perm((l << 5) | r, 10, 8, 1);
        a   = perm(int'(d), 8, 8, 3);
        a   = fk_ref(a, m ? sk2 : sk1, t0, t1);
        a   = ((a & 15) << 4) | (a >> 4);
        a   = fk_ref(a, m ? sk1 : sk2, t0, t1);
        return 8'(perm(a, 8, 8, 4));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_lat(input logic [9:0] k);
`ifdef SDES_CTRL_KEY_CACHE_EN
        return (cvalid && k == clast) ? 3 : 4;
`else
        return 4;
`endif
    endfunction

    // One full request: accept, optional in_valid glitch while busy, latency and
    // result check, `hold` cycles of backpressure, then the output handshake.
    task automatic do_req(input logic m, input logic [7:0] d, input logic [9:0] k,
                          input logic [31:0] t0, input logic [31:0] t1, input logic [7:0] expd,
                          input int hold, input bit glitch, input string tag);
        int lat, want;
        want = exp_lat(k);
        bus.mode     = m;
        bus.data_in  = d;
        bus.key      = k;
        bus.S0       = t0;
        bus.S1       = t1;
        bus.in_valid = 1'b1;
        chk({tag, "_in_ready_idle"}, 32'(bus.in_ready), 32'd1);
        tick();
        lat = 1;
        bus.in_valid = 1'b0;
        bus.data_in  = 8'($urandom);
        bus.key      = 10'($urandom);
        bus.mode     = ~m;
        bus.S0       = $urandom;
        bus.S1       = $urandom;
        if (glitch) begin
            bus.in_valid = 1'b1;
            bus.data_in  = 8'hFF;
            tick();
            lat++;
            bus.in_valid = 1'b0;
        end
        while (!bus.out_valid && lat < 12) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(want));
        chk({tag, "_data_out"}, 32'(bus.data_out), 32'(expd));
        chk({tag, "_busy_done"}, 32'(busy), 32'd1);
        chk({tag, "_in_ready_done"}, 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
            chk({tag, "_hold_data"}, 32'(bus.data_out), 32'(expd));
            chk({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, "_post_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_post_in_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_post_busy"}, 32'(busy), 32'd0);
        cvalid = 1'b1;
        clast  = k;
    endtask

    initial begin
        logic       rm;
        logic [7:0] rd;
        logic [9:0] rk;
        logic [31:0] r0, r1;
        int         stray;

        n_chk = 0;
        n_err = 0;
        cvalid = 1'b0;
        clast  = '0;
        reset  = 1'b0;
        bus.in_valid  = 1'b0;
        bus.mode      = 1'b0;
        bus.data_in   = '0;
        bus.key       = '0;
        bus.S0        = '0;
        bus.S1        = '0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_data_out", 32'(bus.data_out), 32'h00);

        do_req(1'b0, 8'h72, 10'h282, S0_STD, S1_STD, 8'h77, 0, 1'b0, "enc_std");
        do_req(1'b1, 8'h77, 10'h282, S0_STD, S1_STD, 8'h72, 0, 1'b0, "dec_std");
        do_req(1'b0, 8'h72, 10'h282, S0_STD, S1_STD, 8'h77, 5, 1'b0, "backpressure");
        do_req(1'b0, 8'h72, 10'h282, S0_STD, S1_STD, 8'h77, 0, 1'b1, "busy_ignore");

        // Reset while in ROUND1: nothing may come out afterwards.
        bus.mode     = 1'b0;
        bus.data_in  = 8'h72;
        bus.key      = 10'h282;
        bus.S0       = S0_STD;
        bus.S1       = S1_STD;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        if (exp_lat(10'h282) == 4) tick();
        chk("midop_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        cvalid = 1'b0;
        chk("midop_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midop_in_ready", 32'(bus.in_ready), 32'd1);
        chk("midop_busy_clr", 32'(busy), 32'd0);
        chk("midop_data_out", 32'(bus.data_out), 32'h00);
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.out_valid) stray++;
        end
        chk("midop_no_result", 32'(stray), 32'd0);

        do_req(1'b0, 8'h72, 10'h282, S0_STD, S1_STD, 8'h77, 0, 1'b0, "after_rst");
        do_req(1'b0, 8'h72, 10'h282, S0_STD, S1_STD, 8'h77, 0, 1'b0, "same_key");
        do_req(1'b0, 8'h72, 10'h000, S0_STD, S1_STD, sdes_ref(1'b0, 8'h72, 10'h000, S0_STD, S1_STD),
               0, 1'b0, "key_change");
        do_req(1'b0, 8'h72, 10'h000, S0_STD, S1_STD, sdes_ref(1'b0, 8'h72, 10'h000, S0_STD, S1_STD),
               0, 1'b0, "key_zero_again");

        for (int n = 0; n < 40; n++) begin
            rm = 1'($urandom);
            rd = 8'($urandom);
            rk = ($urandom_range(0, 2) == 0) ? clast : 10'($urandom);
            r0 = ($urandom_range(0, 1) == 0) ? S0_STD : $urandom;
            r1 = ($urandom_range(0, 1) == 0) ? S1_STD : $urandom;
            do_req(rm, rd, rk, r0, r1, sdes_ref(rm, rd, rk, r0, r1),
                   $urandom_range(0, 3), 1'($urandom), "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
